// File: rtl/apb_mailbox_slave.sv
// apb_mailbox_slave
//   APB slave giving software a buffered mailbox: an outbound (TX) word FIFO
//   drained by a valid/ready stream, an inbound (RX) word FIFO filled by a
//   valid/ready stream, a STATUS register, an IRQ enable register and a
//   registered level interrupt.
// Register map (word offsets):
//   0x00 TXDATA  W: push into TX (slverr when full)   R: 0
//   0x04 RXDATA  R: pop RX head (slverr when empty)   W: ignored
//   0x08 STATUS  R: [0] tx_full [1] tx_empty [2] rx_full [3] rx_empty
//                   [15:8] tx_count [23:16] rx_count
//   0x0C IRQEN   RW: [0] rx_nonempty_en [1] tx_empty_en
//   others       slverr, prdata=0, no side effect
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   psel/penable/paddr/pwrite/pwdata -> prdata/pready/pslverr  APB slave side
//   tx_valid/tx_ready/tx_data  outbound stream (TX FIFO head)
//   rx_valid/rx_ready/rx_data  inbound stream into RX FIFO
//   irq                      registered level interrupt
module apb_mailbox_slave #(
  parameter int unsigned BW_ADDR = 8,
  parameter int unsigned BW_DATA = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               psel,
  input  logic               penable,
  input  logic [BW_ADDR-1:0] paddr,
  input  logic               pwrite,
  input  logic [BW_DATA-1:0] pwdata,
  output logic [BW_DATA-1:0] prdata,
  output logic               pready,
  output logic               pslverr,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [BW_DATA-1:0] tx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic [BW_DATA-1:0] rx_data,
  output logic               irq
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned AW = PW - 1;
  localparam int unsigned WW = BW_ADDR - 2;

  typedef enum logic {IDLE, RESP} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0]      rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [BW_DATA-1:0] tx_mem [DEPTH];
  logic [BW_DATA-1:0] rx_mem [DEPTH];
  logic [1:0]         irqen_q, irqen_d;
  logic [BW_DATA-1:0] prdata_q, prdata_d;
  logic               pslverr_q, pslverr_d;
  logic               irq_q, irq_d;

  logic [PW-1:0]      tx_cnt, rx_cnt;
  logic               tx_full, tx_empty, rx_full, rx_empty;
  logic               tx_push, tx_pop, rx_push, rx_pop;
  logic [WW-1:0]      widx;
  logic [BW_DATA-1:0] status;
  logic [BW_DATA-1:0] rx_head;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^paddr[1:0];
  assign widx            = paddr[BW_ADDR-1:2];

  // Pointers carry one extra MSB so full and empty differ at equal indices.
  assign tx_cnt   = tx_wr_q - tx_rd_q;
  assign rx_cnt   = rx_wr_q - rx_rd_q;
  assign tx_full  = (tx_cnt == PW'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == PW'(DEPTH));
  assign rx_empty = (rx_cnt == '0);

  assign tx_data  = tx_mem[tx_rd_q[AW-1:0]];
  assign rx_head  = rx_mem[rx_rd_q[AW-1:0]];
  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & rx_ready;

  assign prdata   = prdata_q;
  assign pslverr  = pslverr_q;
  assign pready   = (state_q == RESP);
  assign irq      = irq_q;

  always_comb begin
    status        = '0;
    status[0]     = tx_full;
    status[1]     = tx_empty;
    status[2]     = rx_full;
    status[3]     = rx_empty;
    status[15:8]  = 8'(tx_cnt);
    status[23:16] = 8'(rx_cnt);
  end

  always_comb begin
    state_d   = state_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    irqen_d   = irqen_q;
    tx_push   = 1'b0;
    rx_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && penable) begin
          state_d   = RESP;
          prdata_d  = '0;
          pslverr_d = 1'b0;
          if (pwrite) begin
            case (widx)
              WW'(0): begin
                if (tx_full) pslverr_d = 1'b1;
                else         tx_push   = 1'b1;
              end
              WW'(1), WW'(2): ;
              WW'(3): irqen_d = pwdata[1:0];
              default: pslverr_d = 1'b1;
            endcase
          end else begin
            case (widx)
              WW'(0): ;
              WW'(1): begin
                if (rx_empty) pslverr_d = 1'b1;
                else begin
                  rx_pop   = 1'b1;
                  prdata_d = rx_head;
                end
              end
              WW'(2): prdata_d = status;
              WW'(3): prdata_d = {{(BW_DATA-2){1'b0}}, irqen_q};
              default: pslverr_d = 1'b1;
            endcase
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    tx_wr_d = tx_push ? tx_wr_q + PW'(1) : tx_wr_q;
    tx_rd_d = tx_pop  ? tx_rd_q + PW'(1) : tx_rd_q;
    rx_wr_d = rx_push ? rx_wr_q + PW'(1) : rx_wr_q;
    rx_rd_d = rx_pop  ? rx_rd_q + PW'(1) : rx_rd_q;

    // Built from registered FIFO/IRQEN state, so irq trails each change by a cycle.
    irq_d = (irqen_q[0] & ~rx_empty) | (irqen_q[1] & tx_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      irqen_q   <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_wr_q   <= tx_wr_d;
      tx_rd_q   <= tx_rd_d;
      rx_wr_q   <= rx_wr_d;
      rx_rd_q   <= rx_rd_d;
      irqen_q   <= irqen_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      irq_q     <= irq_d;
    end
  end

  // Storage needs no reset: contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= pwdata;
    if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_apb_mailbox_slave.sv
// Self-checking bench for apb_mailbox_slave (BW_ADDR=8, BW_DATA=32, DEPTH=4).
module tb_apb_mailbox_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        tx_valid, tx_ready;
  logic [31:0] tx_data;
  logic        rx_valid, rx_ready;
  logic [31:0] rx_data;
  logic        irq;

  int n_tests  = 0;
  int n_fail   = 0;
  int tx_beats = 0;

  logic [32:0] exp_q [$];
  logic [31:0] tx_exp [$];

  apb_mailbox_slave #(.BW_ADDR(8), .BW_DATA(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Outbound stream monitor: each accepted beat must match the oldest pushed word.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      tx_beats++;
      if (tx_exp.size() == 0) check("tx_extra", tx_data, 32'hxxxx_xxxx);
      else                    check("tx_data", tx_data, tx_exp.pop_front());
    end
  end

  task automatic apb(input logic [7:0] addr, input logic wr, input logic [31:0] wd,
                     input logic [31:0] erd, input logic eerr, input string tag);
    logic [32:0] e;
    int n;
    exp_q.push_back({eerr, erd});
    if (wr && addr == 8'h00 && !eerr) tx_exp.push_back(wd);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    @(negedge clk);
    while (!pready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd1);
    e = exp_q.pop_front();
    if (pready) begin
      check({tag, "_rdata"}, prdata, e[31:0]);
      check({tag, "_err"}, {31'b0, pslverr}, {31'b0, e[32]});
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rx_send(input logic [31:0] d);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = d;
    @(negedge clk);
    check("rx_ready", {31'b0, rx_ready}, 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x%08h expected 0x%08h", n_tests, 0);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pready",   {31'b0, pready},   32'd0);
    check("rst_pslverr",  {31'b0, pslverr},  32'd0);
    check("rst_prdata",   prdata,            32'd0);
    check("rst_irq",      {31'b0, irq},      32'd0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Empty status after reset.
    apb(8'h08, 1'b0, '0, 32'h0000_000A, 1'b0, "status0");

    // Fill TX with the consumer stalled, overflow once, then drain.
    apb(8'h00, 1'b1, 32'h11, '0, 1'b0, "tx1");
    apb(8'h00, 1'b1, 32'h22, '0, 1'b0, "tx2");
    apb(8'h00, 1'b1, 32'h33, '0, 1'b0, "tx3");
    apb(8'h00, 1'b1, 32'h44, '0, 1'b0, "tx4");
    apb(8'h00, 1'b1, 32'h55, '0, 1'b1, "tx5_full");
    apb(8'h08, 1'b0, '0, 32'h0000_0409, 1'b0, "status_full");
    tx_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("tx_drained",  {31'b0, tx_valid}, 32'd0);
    check("tx_q_empty",  32'(tx_exp.size()), 32'd0);
    check("tx_beats4",   32'(tx_beats), 32'd4);
    tx_ready = 1'b0;

    // RX path and read-only/ignored accesses.
    apb(8'h00, 1'b0, '0, '0, 1'b0, "txdata_rd");
    apb(8'h04, 1'b1, 32'hFFFF_FFFF, '0, 1'b0, "rxdata_wr");
    apb(8'h04, 1'b0, '0, '0, 1'b1, "rx_empty_rd");
    rx_send(32'hA5A5_A5A5);
    apb(8'h04, 1'b0, '0, 32'hA5A5_A5A5, 1'b0, "rx_rd");

    // Interrupt from RX non-empty.
    apb(8'h0C, 1'b1, 32'hFFFF_FFFD, '0, 1'b0, "irqen_wr");
    apb(8'h0C, 1'b0, '0, 32'h1, 1'b0, "irqen_rd");
    check("irq_idle", {31'b0, irq}, 32'd0);
    rx_send(32'hC0DE_0001);
    @(negedge clk);
    check("irq_lag", {31'b0, irq}, 32'd0);
    @(negedge clk);
    check("irq_set", {31'b0, irq}, 32'd1);
    apb(8'h04, 1'b0, '0, 32'hC0DE_0001, 1'b0, "irq_pop");
    check("irq_clr", {31'b0, irq}, 32'd0);

    // Interrupt from TX empty.
    apb(8'h0C, 1'b1, 32'h2, '0, 1'b0, "irqen_tx");
    check("irq_txe", {31'b0, irq}, 32'd1);
    apb(8'h0C, 1'b1, 32'h0, '0, 1'b0, "irqen_off");
    check("irq_off", {31'b0, irq}, 32'd0);

    // Continuous drain across pointer wrap.
    tx_ready = 1'b1;
    for (int i = 0; i < 12; i++)
      apb(8'h00, 1'b1, 32'hB000_0000 + 32'(i), '0, 1'b0, "tx_wrap");
    repeat (4) @(negedge clk);
    check("wrap_q_empty", 32'(tx_exp.size()), 32'd0);
    check("wrap_beats",   32'(tx_beats), 32'd16);
    check("wrap_valid",   {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // Unmapped offset.
    apb(8'h10, 1'b0, '0, '0, 1'b1, "bad_rd");
    apb(8'h10, 1'b1, 32'h1234, '0, 1'b1, "bad_wr");
    apb(8'h08, 1'b0, '0, 32'h0000_000A, 1'b0, "status_bad");

    // Reset during the response phase of a TX push.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 8'h00; pwrite = 1'b1; pwdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_pready", {31'b0, pready},   32'd1);
    check("rst_mid_txv",    {31'b0, tx_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_abort_pready", {31'b0, pready},   32'd0);
    check("rst_abort_txv",    {31'b0, tx_valid}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    apb(8'h08, 1'b0, '0, 32'h0000_000A, 1'b0, "status_post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
